// File: rtl/bcu_pkg.sv
// Shared types and constants for the bus control unit.
package bcu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    ADDR = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } bcu_state_t;

  localparam int TIMEOUT_DEFAULT = 15;

  // Read data returned on a timed-out read; sliced down to DW (DW <= 64).
  localparam int ERR_FILL_W = 64;
  localparam logic [ERR_FILL_W-1:0] ERR_RDATA_FILL = '1;

endpackage

// File: rtl/bcu_timeout_ctr.sv
// WAIT-state cycle counter: cleared on ADDR, saturating, flags the last allowed cycle.
module bcu_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg < LAST)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign terminal = (count_reg == LAST);

endmodule

// File: rtl/bcu_bus_ctrl.sv
// Bus control unit: turns MAU request levels into arbitrated bus transactions with
// four-phase done handshake and acknowledge timeout.
module bcu_bus_ctrl
  import bcu_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          BCURequest_n,
  input  logic          BCUWriteRequest_n,
  input  logic          BCUDataOE,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WData,
  output logic [DW-1:0] RData,
  output logic          ReadDoneFromBCU_n,
  output logic          WriteDoneFromBCU_n,
  output logic          BusReq_n,
  input  logic          BusGrant_n,
  output logic          AddrStrobe_n,
  output logic          BusWrite,
  output logic [AW-1:0] BusAddr,
  output logic [DW-1:0] BusWData,
  output logic          BusDataOE,
  input  logic [DW-1:0] BusRData,
  input  logic          BusAck_n,
  output logic          BusErr
);

  bcu_state_t    state_reg;
  logic          write_flag_reg;
  logic [DW-1:0] rdata_reg;
  logic          read_done_n_reg;
  logic          write_done_n_reg;
  logic          bus_req_n_reg;
  logic          addr_strobe_n_reg;
  logic          bus_write_reg;
  logic [AW-1:0] bus_addr_reg;
  logic [DW-1:0] bus_wdata_reg;
  logic          bus_data_oe_reg;
  logic          bus_err_reg;
  logic          tmo_terminal;
  logic          req_released;

  bcu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clear    (state_reg == ADDR),
    .enable   ((state_reg == WAIT) && BusAck_n),
    .terminal (tmo_terminal)
  );

  // The request that owns the current transaction has been dropped by the MAU.
  assign req_released = write_flag_reg ? BCUWriteRequest_n : BCURequest_n;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg         <= IDLE;
      write_flag_reg    <= 1'b0;
      rdata_reg         <= '0;
      read_done_n_reg   <= 1'b1;
      write_done_n_reg  <= 1'b1;
      bus_req_n_reg     <= 1'b1;
      addr_strobe_n_reg <= 1'b1;
      bus_write_reg     <= 1'b0;
      bus_addr_reg      <= '0;
      bus_wdata_reg     <= '0;
      bus_data_oe_reg   <= 1'b0;
      bus_err_reg       <= 1'b0;
    end else begin
      addr_strobe_n_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          // A pending write blocks the read until its data is valid, so write always wins.
          if (!BCUWriteRequest_n) begin
            if (BCUDataOE) begin
              write_flag_reg <= 1'b1;
              bus_addr_reg   <= Addr;
              bus_wdata_reg  <= WData;
              bus_req_n_reg  <= 1'b0;
              state_reg      <= ARB;
            end
          end else if (!BCURequest_n) begin
            write_flag_reg <= 1'b0;
            bus_addr_reg   <= Addr;
            bus_req_n_reg  <= 1'b0;
            state_reg      <= ARB;
          end
        end
        ARB: begin
          if (!BusGrant_n) begin
            addr_strobe_n_reg <= 1'b0;
            bus_write_reg     <= write_flag_reg;
            bus_data_oe_reg   <= write_flag_reg;
            state_reg         <= ADDR;
          end
        end
        ADDR: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (!BusAck_n || tmo_terminal) begin
            if (!write_flag_reg) begin
              rdata_reg <= BusAck_n ? ERR_RDATA_FILL[DW-1:0] : BusRData;
            end
            if (BusAck_n) begin
              bus_err_reg <= 1'b1;
            end
            if (write_flag_reg) begin
              write_done_n_reg <= 1'b0;
            end else begin
              read_done_n_reg <= 1'b0;
            end
            bus_req_n_reg   <= 1'b1;
            bus_write_reg   <= 1'b0;
            bus_data_oe_reg <= 1'b0;
            state_reg       <= DONE;
          end
        end
        DONE: begin
          if (req_released) begin
            read_done_n_reg  <= 1'b1;
            write_done_n_reg <= 1'b1;
            state_reg        <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign RData              = rdata_reg;
  assign ReadDoneFromBCU_n  = read_done_n_reg;
  assign WriteDoneFromBCU_n = write_done_n_reg;
  assign BusReq_n           = bus_req_n_reg;
  assign AddrStrobe_n       = addr_strobe_n_reg;
  assign BusWrite           = bus_write_reg;
  assign BusAddr            = bus_addr_reg;
  assign BusWData           = bus_wdata_reg;
  assign BusDataOE          = bus_data_oe_reg;
  assign BusErr             = bus_err_reg;

endmodule
